// File: rtl/config_cmd_pkg.sv
// -----------------------------------------------------------------------------
// config_cmd_pkg
//   Shared definitions for the configuration command decoder: the three command
//   opcodes, the decoder FSM state type and a small opcode classification helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package config_cmd_pkg;

   localparam logic [7:0] OP_WRITE    = 8'hA5;   // op, addr, data
   localparam logic [7:0] OP_READ     = 8'h5A;   // op, addr
   localparam logic [7:0] OP_DEFAULTS = 8'hC3;   // op only

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      ISSUE_RD,
      WAIT_RD,
      SEND
   } state_t;

   // True for opcodes that are followed by at least an address byte.
   function automatic logic is_packet_opcode(input logic [7:0] b);
      return (b == OP_WRITE) || (b == OP_READ);
   endfunction

endpackage

// File: rtl/cfg_timeout_counter.sv
// -----------------------------------------------------------------------------
// cfg_timeout_counter
//   Inter-byte timeout counter. Counts enabled cycles since the last clear and
//   saturates at TIMEOUT_CYCLES; expired is high while the count sits there.
// Ports:
//   clk      in  1  system clock
//   reset_n  in  1  synchronous active-low reset (count -> 0)
//   clear    in  1  restart the count (has priority over enable)
//   enable   in  1  advance the count by one this cycle
//   expired  out 1  count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module cfg_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != LIMIT)) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/config_cmd_decoder.sv
// -----------------------------------------------------------------------------
// config_cmd_decoder
//   Byte-stream command parser in front of the configuration register file.
//   Collects write (A5 addr data), read (5A addr) and load-defaults (C3)
//   commands, issues single-cycle regfile strobes, returns read data to the
//   serial transmitter with a valid/ready handshake, and aborts packets whose
//   bytes are spaced too far apart. Every output comes straight from a register.
// Ports:
//   clk                  in  1  system clock
//   reset_n              in  1  synchronous active-low reset
//   rx_data/rx_valid     in  8/1 command byte stream; taken when rx_valid & rx_ready
//   rx_ready             out 1  decoder can take a byte (IDLE/GET_ADDR/GET_DATA)
//   write/write_addr/write_data out 1/8/8  regfile write strobe and operands
//   read/read_addr       out 1/8 regfile read strobe and address
//   read_data            in  8  regfile readback, valid the cycle after read
//   load_config_defaults out 1  regfile defaults-load strobe
//   tx_data/tx_valid     out 8/1 read response, held until tx_ready
//   tx_ready             in  1  transmitter accepts tx_data
//   cmd_error            out 1  pulse on bad opcode or inter-byte timeout
//   busy                 out 1  FSM is not in IDLE
// -----------------------------------------------------------------------------
module config_cmd_decoder
   import config_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       write,
   output logic [7:0] write_addr,
   output logic [7:0] write_data,
   output logic       read,
   output logic [7:0] read_addr,
   input  logic [7:0] read_data,
   output logic       load_config_defaults,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       cmd_error,
   output logic       busy
);

   state_t     state_reg,      state_next;
   logic [7:0] opcode_reg,     opcode_next;
   logic [7:0] addr_reg,       addr_next;
   logic       write_reg,      write_next;
   logic [7:0] write_addr_reg, write_addr_next;
   logic [7:0] write_data_reg, write_data_next;
   logic       read_reg,       read_next;
   logic [7:0] read_addr_reg,  read_addr_next;
   logic       load_reg,       load_next;
   logic [7:0] tx_data_reg,    tx_data_next;
   logic       tx_valid_reg,   tx_valid_next;
   logic       cmd_error_reg,  cmd_error_next;
   logic       rx_ready_reg,   rx_ready_next;
   logic       busy_reg,       busy_next;

   logic accept;
   logic counting;
   logic timeout_expired;

   assign accept   = rx_valid && rx_ready_reg;
   assign counting = (state_reg == GET_ADDR) || (state_reg == GET_DATA);

   // Any accepted byte restarts the gap measurement; it only advances while a
   // packet is partially received.
   cfg_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (accept),
      .enable  (counting),
      .expired (timeout_expired)
   );

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         opcode_reg     <= '0;
         addr_reg       <= '0;
         write_reg      <= 1'b0;
         write_addr_reg <= '0;
         write_data_reg <= '0;
         read_reg       <= 1'b0;
         read_addr_reg  <= '0;
         load_reg       <= 1'b0;
         tx_data_reg    <= '0;
         tx_valid_reg   <= 1'b0;
         cmd_error_reg  <= 1'b0;
         rx_ready_reg   <= 1'b1;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         opcode_reg     <= opcode_next;
         addr_reg       <= addr_next;
         write_reg      <= write_next;
         write_addr_reg <= write_addr_next;
         write_data_reg <= write_data_next;
         read_reg       <= read_next;
         read_addr_reg  <= read_addr_next;
         load_reg       <= load_next;
         tx_data_reg    <= tx_data_next;
         tx_valid_reg   <= tx_valid_next;
         cmd_error_reg  <= cmd_error_next;
         rx_ready_reg   <= rx_ready_next;
         busy_reg       <= busy_next;
      end
   end

   // -------------------------------------------------- next state / outputs
   always_comb begin
      state_next      = state_reg;
      opcode_next     = opcode_reg;
      addr_next       = addr_reg;
      write_next      = 1'b0;
      write_addr_next = write_addr_reg;
      write_data_next = write_data_reg;
      read_next       = 1'b0;
      read_addr_next  = read_addr_reg;
      load_next       = 1'b0;
      tx_data_next    = tx_data_reg;
      tx_valid_next   = tx_valid_reg;
      cmd_error_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (is_packet_opcode(rx_data)) begin
                  opcode_next = rx_data;
                  state_next  = GET_ADDR;
               end else if (rx_data == OP_DEFAULTS) begin
                  load_next = 1'b1;
               end else begin
                  cmd_error_next = 1'b1;
               end
            end
         end

         GET_ADDR: begin
            // A byte arriving in the expiry cycle still counts.
            if (accept) begin
               addr_next = rx_data;
               if (opcode_reg == OP_WRITE) begin
                  state_next = GET_DATA;
               end else begin
                  // The read strobe is registered, so it is launched here and
                  // is high for exactly the ISSUE_RD cycle.
                  read_next      = 1'b1;
                  read_addr_next = rx_data;
                  state_next     = ISSUE_RD;
               end
            end else if (timeout_expired) begin
               cmd_error_next = 1'b1;
               state_next     = IDLE;
            end
         end

         GET_DATA: begin
            if (accept) begin
               write_next      = 1'b1;
               write_addr_next = addr_reg;
               write_data_next = rx_data;
               state_next      = IDLE;
            end else if (timeout_expired) begin
               cmd_error_next = 1'b1;
               state_next     = IDLE;
            end
         end

         ISSUE_RD: begin
            // Regfile registers the read at the end of this cycle.
            state_next = WAIT_RD;
         end

         WAIT_RD: begin
            tx_data_next  = read_data;
            tx_valid_next = 1'b1;
            state_next    = SEND;
         end

         SEND: begin
            if (tx_ready) begin
               tx_valid_next = 1'b0;
               state_next    = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Derived from the upcoming state so both flags are plain registers.
      rx_ready_next = (state_next == IDLE) || (state_next == GET_ADDR) ||
                      (state_next == GET_DATA);
      busy_next     = (state_next != IDLE);
   end

   assign rx_ready             = rx_ready_reg;
   assign write                = write_reg;
   assign write_addr           = write_addr_reg;
   assign write_data           = write_data_reg;
   assign read                 = read_reg;
   assign read_addr            = read_addr_reg;
   assign load_config_defaults = load_reg;
   assign tx_data              = tx_data_reg;
   assign tx_valid             = tx_valid_reg;
   assign cmd_error            = cmd_error_reg;
   assign busy                 = busy_reg;

endmodule

// File: tb/tb_config_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_config_cmd_decoder
//   Directed scenarios followed by randomized command traffic. A packet-level
//   reference model (byte queue + gap counter + read phase) predicts every
//   output after every clock edge; a simple regfile stand-in answers reads.
// -----------------------------------------------------------------------------
module tb_config_cmd_decoder;

   localparam int TO = 1024;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       write;
   logic [7:0] write_addr;
   logic [7:0] write_data;
   logic       read;
   logic [7:0] read_addr;
   logic [7:0] read_data;
   logic       load_config_defaults;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       cmd_error;
   logic       busy;

   always #5 clk = ~clk;

   config_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .rx_data              (rx_data),
      .rx_valid             (rx_valid),
      .rx_ready             (rx_ready),
      .write                (write),
      .write_addr           (write_addr),
      .write_data           (write_data),
      .read                 (read),
      .read_addr            (read_addr),
      .read_data            (read_data),
      .load_config_defaults (load_config_defaults),
      .tx_data              (tx_data),
      .tx_valid             (tx_valid),
      .tx_ready             (tx_ready),
      .cmd_error            (cmd_error),
      .busy                 (busy)
   );

   // Regfile stand-in: registered read, data valid the cycle after read.
   logic [7:0] regmem [256];
   logic       mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) regmem[i] <= 8'(i * 29 + 7);
         mem_ready <= 1'b1;
      end else begin
         if (write) regmem[write_addr] <= write_data;
         if (read)  read_data <= regmem[read_addr];
      end
   end

   // ------------------------------------------------------ reference model
   logic [7:0] model_mem [256];
   logic [7:0] m_pkt [$];
   int         m_gap;
   int         m_rd;        // 0 none, 1 strobe cycle, 2 data wait, 3 sending
   logic       m_rx_ready, m_write, m_read, m_load, m_err, m_txv, m_busy;
   logic [7:0] m_waddr, m_wdata, m_raddr, m_txd;

   int vectors    = 0;
   int miscompares = 0;
   bit rand_tx    = 1'b0;

   task automatic model_step();
      m_write = 1'b0; m_read = 1'b0; m_load = 1'b0; m_err = 1'b0;
      if (!reset_n) begin
         m_pkt.delete(); m_gap = 0; m_rd = 0;
         m_waddr = 8'h00; m_wdata = 8'h00; m_raddr = 8'h00;
         m_txv = 1'b0; m_txd = 8'h00;
      end else if (m_rd == 1) begin
         m_rd = 2;
      end else if (m_rd == 2) begin
         m_txd = model_mem[m_raddr]; m_txv = 1'b1; m_rd = 3;
      end else if (m_rd == 3) begin
         if (tx_ready) begin m_txv = 1'b0; m_rd = 0; end
      end else if (rx_valid) begin
         m_pkt.push_back(rx_data); m_gap = 0;
         if (m_pkt[0] == 8'hC3) begin
            m_load = 1'b1; m_pkt.delete();
         end else if (m_pkt[0] != 8'hA5 && m_pkt[0] != 8'h5A) begin
            m_err = 1'b1; m_pkt.delete();
         end else if (m_pkt[0] == 8'hA5 && m_pkt.size() == 3) begin
            m_write = 1'b1; m_waddr = m_pkt[1]; m_wdata = m_pkt[2];
            model_mem[m_pkt[1]] = m_pkt[2];
            m_pkt.delete();
         end else if (m_pkt[0] == 8'h5A && m_pkt.size() == 2) begin
            m_read = 1'b1; m_raddr = m_pkt[1]; m_rd = 1;
            m_pkt.delete();
         end
      end else if (m_pkt.size() > 0) begin
         if (m_gap == TO) begin
            m_err = 1'b1; m_pkt.delete(); m_gap = 0;
         end else begin
            m_gap++;
         end
      end
      m_rx_ready = (m_rd == 0);
      m_busy     = (m_pkt.size() != 0) || (m_rd != 0);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      vectors++;
      chk1("rx_ready",   rx_ready,             m_rx_ready);
      chk1("write",      write,                m_write);
      chk8("write_addr", write_addr,           m_waddr);
      chk8("write_data", write_data,           m_wdata);
      chk1("read",       read,                 m_read);
      chk8("read_addr",  read_addr,            m_raddr);
      chk1("load",       load_config_defaults, m_load);
      chk1("cmd_error",  cmd_error,            m_err);
      chk1("tx_valid",   tx_valid,             m_txv);
      chk8("tx_data",    tx_data,              m_txd);
      chk1("busy",       busy,                 m_busy);
   endtask

   task automatic step();
      if (rand_tx) tx_ready = ($urandom_range(0, 2) == 0);
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic send(input logic [7:0] b);
      int waited;
      waited   = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!m_rx_ready) begin
         step();
         waited++;
         if (waited > 200) begin
            miscompares++;
            $error("FAIL send_wait observed=rx_ready low for %0d cycles expected=accept", waited);
            break;
         end
      end
      step();
      $display("rx byte %02h accepted at %0t", b, $time);
      rx_valid = 1'b0;
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      int kind, lat;
      logic [7:0] b;

      for (int i = 0; i < 256; i++) model_mem[i] = 8'(i * 29 + 7);
      reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
      m_gap = 0; m_rd = 0;

      // Reset state
      repeat (3) step();
      chk1("reset_rx_ready", rx_ready, 1'b1);
      chk1("reset_busy",     busy,     1'b0);
      reset_n = 1'b1;
      step();

      // 1. Back-to-back write
      send(8'hA5); send(8'h10); send(8'h3C);
      chk1("t1_write", write, 1'b1);
      chk8("t1_waddr", write_addr, 8'h10);
      chk8("t1_wdata", write_data, 8'h3C);
      idle(2);

      // 2. Read back; tx_valid on the third edge counting the accepting one
      tx_ready = 1'b1;
      send(8'h5A); send(8'h10);
      chk1("t2_read", read, 1'b1);
      lat = 1;
      while (tx_valid !== 1'b1 && lat < 10) begin step(); lat++; end
      chk8("t2_latency", 8'(lat), 8'd3);
      chk8("t2_txdata", tx_data, 8'h3C);
      idle(2);

      // 3. Backpressure for 20 cycles, rx byte offered meanwhile
      tx_ready = 1'b0;
      send(8'h5A); send(8'h10);
      idle(2);
      rx_valid = 1'b1; rx_data = 8'hC3;
      repeat (20) step();
      chk1("t3_hold_valid", tx_valid, 1'b1);
      chk1("t3_rx_blocked", rx_ready, 1'b0);
      rx_valid = 1'b0;
      tx_ready = 1'b1; step();
      chk1("t3_released", tx_valid, 1'b0);
      tx_ready = 1'b0; idle(2);

      // 4. Bad opcode, then a good write
      send(8'h77);
      chk1("t4_err", cmd_error, 1'b1);
      send(8'hA5); send(8'h01); send(8'hFF);
      chk1("t4_write", write, 1'b1);
      idle(1);

      // 5a. Byte arriving in the expiry cycle wins
      send(8'hA5); send(8'h20); idle(TO); send(8'h66);
      chk1("t5_boundary_write", write, 1'b1);
      chk8("t5_boundary_data", write_data, 8'h66);
      // 5b. One idle cycle more aborts the packet
      send(8'hA5); send(8'h20); idle(TO + 1);
      chk1("t5_timeout_err", cmd_error, 1'b1);
      chk1("t5_idle", busy, 1'b0);
      send(8'hC3);
      chk1("t5_next_is_opcode", load_config_defaults, 1'b1);
      idle(1);

      // 6. Reset mid-packet
      send(8'hA5);
      reset_n = 1'b0; step(); step();
      chk1("t6_reset_busy", busy, 1'b0);
      reset_n = 1'b1; idle(3);
      send(8'h10);
      chk1("t6_no_write", write, 1'b0);
      idle(2);

      // Randomized traffic
      rand_tx = 1'b1;
      for (int p = 0; p < 250; p++) begin
         kind = $urandom_range(0, 9);
         if (kind >= 8 && $urandom_range(0, 9) != 0) kind = 0;
         case (kind)
            0, 1, 2: begin
               send(8'hA5); idle($urandom_range(0, 3));
               send(8'($urandom)); idle($urandom_range(0, 3));
               send(8'($urandom));
            end
            3, 4, 5: begin
               send(8'h5A); idle($urandom_range(0, 3));
               send(8'($urandom));
            end
            6: send(8'hC3);
            7: begin
               b = 8'($urandom);
               if (b == 8'hA5 || b == 8'h5A || b == 8'hC3) b = 8'h00;
               send(b);
            end
            8: begin
               send(8'hA5); idle(TO); send(8'($urandom)); send(8'($urandom));
            end
            default: begin
               send(($urandom_range(0, 1) == 0) ? 8'hA5 : 8'h5A);
               idle(TO + 1 + $urandom_range(0, 2));
            end
         endcase
         idle($urandom_range(0, 4));
      end
      rand_tx = 1'b0; tx_ready = 1'b1;
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
